// File: rtl/scan_sel_gen_if.sv
// Scan control inputs and decoder-facing outputs of scan_sel_gen.
// The master side drives run/digit_mask; the slave side (the sequencer)
// drives the select pair, enable, current index and slot pulse.
interface scan_sel_gen_if;
  logic       run;
  logic [3:0] digit_mask;
  logic       w0;
  logic       w1;
  logic       en;
  logic [1:0] digit_idx;
  logic       slot_start;

  modport master (
    output run,
    output digit_mask,
    input  w0,
    input  w1,
    input  en,
    input  digit_idx,
    input  slot_start
  );

  modport slave (
    input  run,
    input  digit_mask,
    output w0,
    output w1,
    output en,
    output digit_idx,
    output slot_start
  );
endinterface

// File: rtl/scan_sel_gen.sv
// Digit-scan sequencer feeding a 2-to-4 one-hot decoder.
// Each slot lasts DIV cycles: the first BLANK cycles keep the decoder
// disabled to avoid ghosting, then the enable is held for the rest of
// the slot. Masked digits are skipped when choosing the next slot.
module scan_sel_gen #(
  parameter int DIV_W = 16,
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input logic          clk,
  input logic          rst,
  scan_sel_gen_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  // With no blanking a slot opens straight into the enabled phase.
  localparam logic       START_ON  = (BLANK == 0);
  localparam logic [1:0] ST_START  = START_ON ? ST_ON : ST_BLANK;

  localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] CNT_BLANK = DIV_W'(BLANK);

  logic [1:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [1:0]       idx;
  logic             en_q;
  logic             start_q;
  logic             kill;

  logic [1:0]       first_idx;
  logic [1:0]       next_idx;
  logic [DIV_W-1:0] cnt_inc;
  logic             kill_nxt;
  logic             on_nxt;

  // Digit selection, counter increment and mid-slot enable decisions.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.digit_mask[i]) first_idx = 2'(i);
    end

    // Search idx+1, idx+2, idx+3, idx; descending loop lets the nearest win.
    next_idx = idx;
    for (int d = 4; d >= 1; d--) begin
      if (bus.digit_mask[idx + 2'(d)]) next_idx = idx + 2'(d);
    end

    cnt_inc  = cnt + DIV_W'(1);
    // Once the shown digit is masked out, the enable stays off until slot end.
    kill_nxt = kill | ~bus.digit_mask[idx];
    on_nxt   = (state == ST_ON) || (cnt_inc == CNT_BLANK);
  end

  // Slot sequencing: start, blank-to-on, slot end, stop and mask handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= 2'd0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      kill    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.run && (bus.digit_mask != 4'd0)) begin
            state   <= ST_START;
            cnt     <= '0;
            idx     <= first_idx;
            en_q    <= START_ON;
            start_q <= 1'b1;
            kill    <= 1'b0;
          end
        end
        ST_BLANK, ST_ON: begin
          if (!bus.run || ((cnt == CNT_LAST) && (bus.digit_mask == 4'd0))) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= 2'd0;
            en_q  <= 1'b0;
            kill  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_START;
            cnt     <= '0;
            idx     <= next_idx;
            en_q    <= START_ON;
            start_q <= 1'b1;
            kill    <= 1'b0;
          end else begin
            cnt  <= cnt_inc;
            kill <= kill_nxt;
            en_q <= on_nxt && !kill_nxt;
            if (on_nxt) state <= ST_ON;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          idx   <= 2'd0;
          en_q  <= 1'b0;
          kill  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.w0         = idx[0];
  assign bus.w1         = idx[1];
  assign bus.digit_idx  = idx;
  assign bus.en         = en_q;
  assign bus.slot_start = start_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: two instances (DIV=8/BLANK=2 and DIV=4/BLANK=0)
// checked cycle by cycle against a slot-position model through queues,
// plus directed checks of slot counts, index order and async reset.
module tb_scan_sel_gen;

  typedef struct {
    logic       en;
    logic [1:0] idx;
    logic       ss;
  } exp_t;

  logic clk;
  logic rst;

  scan_sel_gen_if if_a ();
  scan_sel_gen_if if_b ();

  scan_sel_gen #(.DIV_W(16), .DIV(8), .BLANK(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  scan_sel_gen #(.DIV_W(16), .DIV(4), .BLANK(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int   m_k[2];
  int   m_idx[2];
  bit   m_act[2];
  bit   m_kill[2];
  bit   m_ss[2];

  int   en_cnt_a, ss_cnt_a, en_cnt_b, ss_cnt_b;
  int   ss_idx_a[$];

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_k[i] = 0; m_idx[i] = 0; m_act[i] = 0; m_kill[i] = 0; m_ss[i] = 0;
    end
  endtask

  task automatic clearStats();
    en_cnt_a = 0; ss_cnt_a = 0; en_cnt_b = 0; ss_cnt_b = 0;
    ss_idx_a.delete();
  endtask

  // Slot-position model: advance one clock edge and queue the outputs it implies.
  task automatic modelStep(input int i, input int div, input int blank,
                           input logic run, input logic [3:0] mask);
    exp_t e;
    bit   found;
    m_ss[i] = 0;
    if (!m_act[i]) begin
      m_idx[i] = 0;
      if (run && mask != 4'd0) begin
        found = 0;
        for (int d = 0; d < 4; d++) begin
          if (!found && mask[d]) begin m_idx[i] = d; found = 1; end
        end
        m_act[i] = 1; m_k[i] = 0; m_kill[i] = 0; m_ss[i] = 1;
      end
    end else if (!run) begin
      m_act[i] = 0; m_idx[i] = 0;
    end else if (m_k[i] == div - 1) begin
      if (mask == 4'd0) begin
        m_act[i] = 0; m_idx[i] = 0;
      end else begin
        found = 0;
        for (int d = 1; d <= 4; d++) begin
          if (!found && mask[(m_idx[i] + d) % 4]) begin
            m_idx[i] = (m_idx[i] + d) % 4; found = 1;
          end
        end
        m_k[i] = 0; m_kill[i] = 0; m_ss[i] = 1;
      end
    end else begin
      if (!mask[m_idx[i]]) m_kill[i] = 1;
      m_k[i]++;
    end
    e.en  = m_act[i] && (m_k[i] >= blank) && !m_kill[i];
    e.idx = 2'(m_idx[i]);
    e.ss  = m_ss[i];
    if (i == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  // Pop one expectation per instance and compare against the sampled outputs.
  task automatic compareHead();
    exp_t e;
    if (exp_a.size() == 0) checkOutput("a_queue_empty", 32'd0, 32'd1);
    else begin
      e = exp_a.pop_front();
      checkOutput("a_en",  32'(if_a.en),         32'(e.en));
      checkOutput("a_idx", 32'(if_a.digit_idx),  32'(e.idx));
      checkOutput("a_w0",  32'(if_a.w0),         32'(e.idx[0]));
      checkOutput("a_w1",  32'(if_a.w1),         32'(e.idx[1]));
      checkOutput("a_ss",  32'(if_a.slot_start), 32'(e.ss));
    end
    if (exp_b.size() == 0) checkOutput("b_queue_empty", 32'd0, 32'd1);
    else begin
      e = exp_b.pop_front();
      checkOutput("b_en",  32'(if_b.en),         32'(e.en));
      checkOutput("b_idx", 32'(if_b.digit_idx),  32'(e.idx));
      checkOutput("b_w0",  32'(if_b.w0),         32'(e.idx[0]));
      checkOutput("b_w1",  32'(if_b.w1),         32'(e.idx[1]));
      checkOutput("b_ss",  32'(if_b.slot_start), 32'(e.ss));
    end
    if (if_a.en) en_cnt_a++;
    if (if_b.en) en_cnt_b++;
    if (if_b.slot_start) ss_cnt_b++;
    if (if_a.slot_start) begin
      ss_cnt_a++;
      ss_idx_a.push_back(int'(if_a.digit_idx));
    end
  endtask

  // Drive both instances at the falling edge, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic ra, input logic [3:0] ma,
                               input logic rb, input logic [3:0] mb);
    @(negedge clk);
    if_a.run = ra; if_a.digit_mask = ma;
    if_b.run = rb; if_b.digit_mask = mb;
    modelStep(0, 8, 2, ra, ma);
    modelStep(1, 4, 0, rb, mb);
    @(posedge clk);
    #1;
    compareHead();
  endtask

  task automatic runFor(input int n, input logic ra, input logic [3:0] ma,
                        input logic rb, input logic [3:0] mb);
    for (int c = 0; c < n; c++) applyStimulus(ra, ma, rb, mb);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_a_en"},  32'(if_a.en),         32'd0);
    checkOutput({tag, "_a_w0"},  32'(if_a.w0),         32'd0);
    checkOutput({tag, "_a_w1"},  32'(if_a.w1),         32'd0);
    checkOutput({tag, "_a_ss"},  32'(if_a.slot_start), 32'd0);
    checkOutput({tag, "_a_idx"}, 32'(if_a.digit_idx),  32'd0);
    checkOutput({tag, "_b_en"},  32'(if_b.en),         32'd0);
    checkOutput({tag, "_b_ss"},  32'(if_b.slot_start), 32'd0);
    checkOutput({tag, "_b_idx"}, 32'(if_b.digit_idx),  32'd0);
  endtask

  initial begin
    int t1_exp[5];
    t1_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    if_a.run = 1'b0; if_a.digit_mask = 4'd0;
    if_b.run = 1'b0; if_b.digit_mask = 4'd0;
    modelReset();
    clearStats();
    #3;
    checkZero("reset");
    #19;
    rst = 1'b0;

    $display("[TB] idle with empty mask");
    runFor(3, 1'b1, 4'h0, 1'b0, 4'h0);

    $display("[TB] full scan on both instances");
    clearStats();
    runFor(40, 1'b1, 4'hF, 1'b1, 4'hF);
    checkOutput("t1_ss_cnt", 32'(ss_cnt_a), 32'd5);
    checkOutput("t1_en_cnt", 32'(en_cnt_a), 32'd30);
    checkOutput("t1_idx_n",  32'(ss_idx_a.size()), 32'd5);
    for (int j = 0; j < 5 && j < ss_idx_a.size(); j++)
      checkOutput("t1_idx_seq", 32'(ss_idx_a[j]), 32'(t1_exp[j]));
    checkOutput("t6_en_cnt", 32'(en_cnt_b), 32'd40);
    checkOutput("t6_ss_cnt", 32'(ss_cnt_b), 32'd10);

    runFor(2, 1'b0, 4'hA, 1'b1, 4'hF);

    $display("[TB] mask 1010, instance b mask cleared mid-slot");
    clearStats();
    runFor(32, 1'b1, 4'hA, 1'b1, 4'h0);
    checkOutput("t2_ss_cnt", 32'(ss_cnt_a), 32'd4);
    checkOutput("t2_en_cnt", 32'(en_cnt_a), 32'd24);
    for (int j = 0; j < ss_idx_a.size(); j++)
      checkOutput("t2_idx_seq", 32'(ss_idx_a[j]), (j % 2 == 0) ? 32'd1 : 32'd3);
    checkOutput("t6_cleared_en", 32'(en_cnt_b), 32'd0);
    checkOutput("t6_cleared_ss", 32'(ss_cnt_b), 32'd0);

    $display("[TB] single digit mask 0100");
    runFor(2, 1'b0, 4'h4, 1'b0, 4'h0);
    clearStats();
    runFor(24, 1'b1, 4'h4, 1'b0, 4'h0);
    checkOutput("t3_ss_cnt", 32'(ss_cnt_a), 32'd3);
    checkOutput("t3_en_cnt", 32'(en_cnt_a), 32'd18);
    for (int j = 0; j < ss_idx_a.size(); j++)
      checkOutput("t3_idx", 32'(ss_idx_a[j]), 32'd2);

    $display("[TB] stop mid-slot and restart");
    runFor(2, 1'b0, 4'h6, 1'b0, 4'h0);
    runFor(6, 1'b1, 4'h6, 1'b0, 4'h0);
    applyStimulus(1'b0, 4'h6, 1'b0, 4'h0);
    checkOutput("t4_stop_en", 32'(if_a.en), 32'd0);
    checkOutput("t4_stop_w0", 32'(if_a.w0), 32'd0);
    checkOutput("t4_stop_w1", 32'(if_a.w1), 32'd0);
    applyStimulus(1'b1, 4'h6, 1'b0, 4'h0);
    checkOutput("t4_restart_ss",  32'(if_a.slot_start), 32'd1);
    checkOutput("t4_restart_idx", 32'(if_a.digit_idx),  32'd1);
    checkOutput("t4_restart_en",  32'(if_a.en),         32'd0);
    runFor(2, 1'b1, 4'h6, 1'b0, 4'h0);
    checkOutput("t4_on_en", 32'(if_a.en), 32'd1);

    $display("[TB] current digit masked mid-slot");
    applyStimulus(1'b1, 4'h4, 1'b0, 4'h0);
    checkOutput("kill_en", 32'(if_a.en), 32'd0);
    runFor(4, 1'b1, 4'h4, 1'b0, 4'h0);
    applyStimulus(1'b1, 4'h4, 1'b0, 4'h0);
    checkOutput("kill_next_idx", 32'(if_a.digit_idx),  32'd2);
    checkOutput("kill_next_ss",  32'(if_a.slot_start), 32'd1);

    $display("[TB] async reset during ON");
    runFor(2, 1'b0, 4'hF, 1'b0, 4'hF);
    runFor(5, 1'b1, 4'hF, 1'b1, 4'hF);
    rst = 1'b1;
    #2;
    checkZero("t5_async");
    #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 4'h1, 1'b1, 4'h1);
    checkOutput("t5_ss",  32'(if_a.slot_start), 32'd1);
    checkOutput("t5_idx", 32'(if_a.digit_idx),  32'd0);
    checkOutput("t5_en0", 32'(if_a.en),         32'd0);
    applyStimulus(1'b1, 4'h1, 1'b1, 4'h1);
    checkOutput("t5_en1", 32'(if_a.en), 32'd0);
    applyStimulus(1'b1, 4'h1, 1'b1, 4'h1);
    checkOutput("t5_en2", 32'(if_a.en), 32'd1);

    $display("[TB] random run/mask traffic");
    begin
      logic       ra, rb;
      logic [3:0] ma, mb;
      ma = 4'hF; mb = 4'hF;
      for (int c = 0; c < 400; c++) begin
        ra = ($urandom_range(0, 19) != 0);
        rb = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 9) == 0) ma = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) mb = 4'($urandom_range(0, 15));
        applyStimulus(ra, ma, rb, mb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Upstream sequencer for the 2-to-4 one-hot decoder in the 4-digit display path.
- Produces the decoder's select pair (w0 = LSB, w1 = MSB) and its enable.
- Steps through the four digit positions in time slots of fixed length, skipping masked digits.
- Holds the enable low for a programmable blanking interval at the start of each slot, to stop ghosting between digits.

Parameters:
- DIV_W, 16: width of the slot cycle counter.
- DIV, 50000: slot length in clock cycles. Legal range 2..2^DIV_W-1.
- BLANK, 4: cycles at the start of each slot during which en=0. Legal range 0..DIV-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level: 1 = scanning enabled, 0 = stop.
- digit_mask  input  4  bit i = 1 means digit i takes part in the scan.
- w0  output  1  select LSB to the decoder (equals digit_idx[0]).
- w1  output  1  select MSB to the decoder (equals digit_idx[1]).
- en  output  1  decoder enable.
- digit_idx  output  2  index of the current digit.
- slot_start  output  1  one-cycle pulse on the first cycle of each slot.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset (async, no clock edge needed):
  - state=IDLE, slot counter=0, digit_idx=0.
  - w0=0, w1=0, en=0, slot_start=0.
- States: IDLE, BLANK, ON.
- IDLE:
  - Outputs: en=0, w0=w1=0, digit_idx=0.
  - Leave when run=1 and digit_mask!=0 at a clock edge.
  - digit_idx loads the lowest set bit of digit_mask.
  - Next state is BLANK if BLANK>0, otherwise ON.
  - slot_start=1 in that first cycle and the counter loads 0.
- Slot structure: a slot is exactly DIV cycles, k = 0..DIV-1.
  - w0/w1/digit_idx are constant for the whole slot.
  - en=0 for k<BLANK (BLANK state).
  - en=1 for BLANK<=k<=DIV-1 (ON state).
- BLANK to ON transition: at the edge where k reaches BLANK.
- Slot end (edge after k=DIV-1):
  - digit_mask is sampled in cycle k=DIV-1.
  - Next index = first set bit searching idx+1, idx+2, idx+3, idx (modulo 4, wrap 3->0).
  - If only the current bit is set, the same digit starts a new slot, with its blanking repeated.
  - If the mask is 0, go to IDLE.
  - Otherwise start a new slot: slot_start=1, counter=0, state BLANK (or ON if BLANK=0).
- run=0 in any non-IDLE state:
  - Next edge goes to IDLE, giving en=0 and w0=w1=0 one cycle later.
  - No slot completion.
- Mid-slot mask change:
  - If the current digit's mask bit drops to 0, en is forced to 0 from the next edge for the rest of the slot.
  - The slot still runs to its end, then advances per the sampled mask.
  - Newly set bits only take effect at slot end.
- run=1 with digit_mask=0 in IDLE: stay in IDLE.
- BLANK=0: the BLANK state is never entered; en stays high continuously across slot boundaries while scanning.
- Counter: counts 0..DIV-1 and clears at slot end. No overflow is possible given the legal parameter range.
- Reset asserted mid-slot: outputs clear immediately. After release, the block waits in IDLE for the next edge with run=1.
- Simultaneous run=0 and slot end: run=0 wins, go to IDLE.

Test Plan:
1. DIV=8, BLANK=2, run=1, mask=1111:
   - digit_idx sequence 0,1,2,3,0.
   - Each slot is 8 cycles: en=0 for 2 cycles, en=1 for 6.
   - slot_start pulses every 8 cycles.
   - (w1,w0) = 00,01,10,11.
2. mask=1010 → digit_idx alternates 1,3,1,3. No slot ever shows idx 0 or 2.
3. mask=0100 → digit_idx stays 2; en pattern 0,0,1,1,1,1,1,1 repeats; slot_start every 8 cycles.
4. Assert run=0 at k=5 of a slot → en=0 and w0=w1=0 on the next edge, state IDLE. Re-asserting run restarts at the lowest set mask bit with a blank period.
5. Pulse rst for half a clock period during ON → en, w0, w1, slot_start read 0 before any clock edge. After release with run=1, mask=0001: slot_start, idx 0, en rises after 2 cycles.
6. BLANK=0, DIV=4, mask=1111 → en=1 every cycle after start; idx changes every 4 cycles. Clearing the mask mid-slot drops en on the next edge; IDLE at slot end.
